data_mem_arbiter: RTL

Shares the single-port data memory between two requesters: the CPU datapath (port A) and a DMA/loader engine (port B). Each requester uses a req/ack handshake. The arbiter sequences every memory access as a fixed 3-state transaction and drives the memory's address, write data and read_write lines. It captures read data into a register and returns it with the ack pulse. It sits between the core/DMA and the data memory; the memory writes while read_write and clk are both high, and reads combinationally.

---
 rtl/data_mem_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port data memory between the CPU
// (port A) and a DMA/loader engine (port B). Every access runs as a fixed
// IDLE -> ACCESS -> RESP sequence, so an ack arrives two cycles after the
// request is first seen in IDLE.
//
// Optional build macro: DATA_MEM_ARB_ROUND_ROBIN_EN
//   defined   : ties go to the port that was not granted last
//   undefined : fixed priority, port A always wins ties
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   a_req/a_read_write/a_address/a_write_data, a_ack   CPU request/ack
//   b_req/b_read_write/b_address/b_write_data, b_ack   DMA request/ack
//   read_data                 registered read result, valid with ack
//   mem_address/mem_write_data/mem_read_write          to memory
//   mem_read_data             from memory (combinational read)
//   busy                      high in ACCESS and RESP
//   conflict                  one-cycle pulse after a tied arbitration
module data_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_read_write,
    input  logic [ADDR_WIDTH-1:0] a_address,
    input  logic [DATA_WIDTH-1:0] a_write_data,
    output logic                  a_ack,
    input  logic                  b_req,
    input  logic                  b_read_write,
    input  logic [ADDR_WIDTH-1:0] b_address,
    input  logic [DATA_WIDTH-1:0] b_write_data,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_read_write,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  busy,
    output logic                  conflict
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  rw_q, rw_d;
    logic                  grant_b_q, grant_b_d;
    logic                  last_grant_b_q, last_grant_b_d;
    logic                  pick_b;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic                  mem_rw_d;
    logic                  a_ack_d;
    logic                  b_ack_d;
    logic                  busy_d;
    logic                  conflict_d;

    // Arbitration choice for the current IDLE cycle
    always_comb begin
        pick_b = 1'b0;
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
        pick_b = b_req & (~a_req | ~last_grant_b_q);
`else
        pick_b = b_req & ~a_req;
`endif
    end

    // Next-state and next-output logic
    always_comb begin
        state_d        = state_q;
        rw_d           = rw_q;
        grant_b_d      = grant_b_q;
        last_grant_b_d = last_grant_b_q;
        addr_d         = mem_address;
        wdata_d        = mem_write_data;
        rdata_d        = read_data;
        mem_rw_d       = 1'b0;
        a_ack_d        = 1'b0;
        b_ack_d        = 1'b0;
        busy_d         = busy;
        conflict_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (a_req || b_req) begin
                    addr_d         = pick_b ? b_address    : a_address;
                    wdata_d        = pick_b ? b_write_data : a_write_data;
                    rw_d           = pick_b ? b_read_write : a_read_write;
                    // Strobe is registered so it is high for exactly the ACCESS cycle
                    mem_rw_d       = pick_b ? b_read_write : a_read_write;
                    grant_b_d      = pick_b;
                    last_grant_b_d = pick_b;
                    busy_d         = 1'b1;
                    conflict_d     = a_req & b_req;
                    state_d        = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!rw_q) begin
                    rdata_d = mem_read_data;
                end
                a_ack_d = ~grant_b_q;
                b_ack_d = grant_b_q;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            rw_q           <= 1'b0;
            grant_b_q      <= 1'b0;
            last_grant_b_q <= 1'b1;
            mem_address    <= '0;
            mem_write_data <= '0;
            read_data      <= '0;
            mem_read_write <= 1'b0;
            a_ack          <= 1'b0;
            b_ack          <= 1'b0;
            busy           <= 1'b0;
            conflict       <= 1'b0;
        end else begin
            state_q        <= state_d;
            rw_q           <= rw_d;
            grant_b_q      <= grant_b_d;
            last_grant_b_q <= last_grant_b_d;
            mem_address    <= addr_d;
            mem_write_data <= wdata_d;
            read_data      <= rdata_d;
            mem_read_write <= mem_rw_d;
            a_ack          <= a_ack_d;
            b_ack          <= b_ack_d;
            busy           <= busy_d;
            conflict       <= conflict_d;
        end
    end

endmodule
